// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store sequencer for a single-port, sync-read data memory.
// Sub-word stores do read-modify-write; loads are lane-extracted and extended.
module dmem_lsu #(
  parameter int ADDR_BITS   = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_BITS+1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_misaligned,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, WRITE, RESP
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } op_t;

  state_t               state, state_n;
  op_t                  op, op_n;
  logic [1:0]           cnt, cnt_n;
  logic                 ready_n, rv_n, mis_n, wren_n;
  logic [31:0]          rd_n, data_n;
  logic [ADDR_BITS-1:0] addr_n;
  logic                 accept, misal, wstore;
  logic [4:0]           sh;
  logic [31:0]          mask, lane_q, merged, loaded;

  assign accept = req_valid & req_ready;
  assign misal  = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (|req_addr[1:0]));
  assign wstore = req_write & (req_size == 2'b10) & ~misal;

  // one shift amount serves both the store merge and the load extract
  assign sh     = (op.size == 2'b00) ? {op.lane, 3'b000}
                                     : {op.lane[1], 4'b0000};
  assign mask   = (op.size == 2'b00) ? (32'h0000_00ff << sh)
                                     : (32'h0000_ffff << sh);
  assign merged = (mem_q & ~mask) | ((op.wdata << sh) & mask);
  assign lane_q = mem_q >> sh;

  always_comb begin
    loaded = mem_q;
    unique case (op.size)
      2'b00:   loaded = {{24{op.sgn & lane_q[7]}}, lane_q[7:0]};
      2'b01:   loaded = {{16{op.sgn & lane_q[15]}}, lane_q[15:0]};
      default: loaded = mem_q;
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op;
    cnt_n   = cnt;
    ready_n = 1'b0;
    rv_n    = 1'b0;
    rd_n    = 32'h0;
    mis_n   = 1'b0;
    addr_n  = mem_address;
    data_n  = mem_data;
    wren_n  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (accept) begin
          ready_n = 1'b0;
          op_n    = '{req_write, req_size, req_signed,
                      req_addr[1:0], req_wdata};
          unique case (1'b1)
            misal: begin
              state_n = RESP;
              rv_n    = 1'b1;
              mis_n   = 1'b1;
            end
            wstore: begin
              state_n = WRITE;
              addr_n  = req_addr[ADDR_BITS+1:2];
              data_n  = req_wdata;
              wren_n  = 1'b1;
            end
            default: begin
              state_n = ISSUE;
              addr_n  = req_addr[ADDR_BITS+1:2];
            end
          endcase
        end
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = 2'(MEM_LATENCY - 1);
      end
      WAIT: begin
        if (cnt != 2'd0) begin
          cnt_n = cnt - 2'd1;
        end else if (op.wr) begin
          state_n = WRITE;
          data_n  = merged;
          wren_n  = 1'b1;
        end else begin
          state_n = RESP;
          rv_n    = 1'b1;
          rd_n    = loaded;
        end
      end
      WRITE: begin
        state_n = RESP;
        rv_n    = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op             <= '0;
      cnt            <= 2'd0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 32'h0;
      rsp_misaligned <= 1'b0;
      mem_address    <= '0;
      mem_data       <= 32'h0;
      mem_wren       <= 1'b0;
    end else begin
      state          <= state_n;
      op             <= op_n;
      cnt            <= cnt_n;
      req_ready      <= ready_n;
      rsp_valid      <= rv_n;
      rsp_rdata      <= rd_n;
      rsp_misaligned <= mis_n;
      mem_address    <= addr_n;
      mem_data       <= data_n;
      mem_wren       <= wren_n;
    end
  end

endmodule
